// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small pop-handshake FIFO, sticky error flags and a level irq.
// Define UART_RX_PARITY_EN to receive 8E1/8O1 frames (PARITY_ODD selects the sense).
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       irq
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0] DEPTH    = PW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

    logic          rx_meta_q, rxs_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_q, push_d;
    logic          frame_set;
    logic          frame_q, frame_d;
    logic          ovr_q, ovr_d;
    logic          irq_q, irq_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          parity_set;
    logic          parity_q, parity_d;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count_q, count_d;
    logic [7:0]    last_q, last_d;
    logic          pop, full, push_ok;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        parity_set = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs_q) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == CNT_END) begin
                    cnt_d     = '0;
                    par_bad_d = ((^shift_q) ^ rxs_q) != PARITY_ODD;
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (cnt_q == CNT_END) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        frame_set = 1'b1;
                        state_d   = StBreak;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) begin
                        parity_set = 1'b1;
                        state_d    = StIdle;
                    end
`endif
                    else begin
                        push_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rxs_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A push while full succeeds only if a pop frees the head in the same cycle.
    always_comb begin
        full     = (count_q == DEPTH);
        pop      = rx_ready && (count_q != '0);
        push_ok  = push_q && (!full || pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        last_d   = last_q;
        if (pop) begin
            last_d   = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        count_d = count_q + PW'(push_ok) - PW'(pop);
        frame_d = (frame_q && !err_clr) || frame_set;
        ovr_d   = (ovr_q && !err_clr) || (push_q && !push_ok);
`ifdef UART_RX_PARITY_EN
        parity_d = (parity_q && !err_clr) || parity_set;
`endif
        irq_d = (count_q != '0) | frame_q | parity_err | ovr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
            frame_q   <= 1'b0;
            ovr_q     <= 1'b0;
            irq_q     <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            last_q    <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            parity_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
            frame_q   <= frame_d;
            ovr_q     <= ovr_d;
            irq_q     <= irq_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            last_q    <= last_d;
            mem_q     <= mem_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            parity_q  <= parity_d;
`endif
        end
    end

    assign rx_data   = (count_q == '0) ? last_q : mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid  = (count_q != '0);
    assign frame_err = frame_q;
    assign overrun   = ovr_q;
    assign irq       = irq_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_q;
`else
    // PARITY_ODD has no effect in this build.
    assign parity_err = 1'b0 & PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16, FIFO_DEPTH=4; table-driven single frames
// followed by hand-written overrun, simultaneous push/pop, parity and mid-frame reset cases.
module tb_uart_rx;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Edges from start-bit launch to the FIFO write of that frame.
    localparam int PUSH_EDGE = 156 + (PAR_EN ? CPB : 0);

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_ready = 1'b0, err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun, irq;
    int         n_checks = 0;
    int         n_fail = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_ODD(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_ready  (rx_ready),
        .err_clr   (err_clr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        bit         exp_valid;
        bit         exp_frame;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit par_flip);
        @(posedge clk);
        #1 rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        if (PAR_EN) begin
            rx = (^b) ^ par_flip;
            wait_cycles(CPB);
        end
        rx = stop;
        wait_cycles(CPB);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        chk(name, rx_data, exp);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_frame: 1'b0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_valid: 1'b0, exp_frame: 1'b1};
        vecs[2] = '{data: 8'h11, stop: 1'b1, exp_valid: 1'b1, exp_frame: 1'b0};
        vecs[3] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_frame: 1'b0};
        vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_frame: 1'b0};
        vecs[5] = '{data: 8'h80, stop: 1'b1, exp_valid: 1'b1, exp_frame: 1'b0};

        wait_cycles(5);
        rst = 1'b0;
        wait_cycles(2);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset rx_data", rx_data, 0);
        chk("reset frame_err", frame_err, 0);
        chk("reset parity_err", parity_err, 0);
        chk("reset overrun", overrun, 0);
        chk("reset irq", irq, 0);

        // Short low glitch: false start, nothing received.
        rx = 1'b0;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(3 * CPB);
        chk("glitch rx_valid", rx_valid, 0);
        chk("glitch frame_err", frame_err, 0);
        chk("glitch irq", irq, 0);

        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].stop, 1'b0);
            if (!vecs[i].stop) wait_cycles(40 * CPB);
            wait_cycles(4);
            chk($sformatf("vec%0d rx_valid", i), rx_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d frame_err", i), frame_err, vecs[i].exp_frame);
            chk($sformatf("vec%0d irq", i), irq, 1);
            chk($sformatf("vec%0d overrun", i), overrun, 0);
            chk($sformatf("vec%0d parity_err", i), parity_err, 0);
            if (vecs[i].exp_valid) begin
                pop_check($sformatf("vec%0d rx_data", i), vecs[i].data);
                chk($sformatf("vec%0d rx_valid after pop", i), rx_valid, 0);
                chk($sformatf("vec%0d rx_data held", i), rx_data, vecs[i].data);
            end
            if (vecs[i].exp_frame) begin
                rx = 1'b1;
                wait_cycles(4);
                pulse_clr();
                wait_cycles(2);
                chk($sformatf("vec%0d frame_err cleared", i), frame_err, 0);
                chk($sformatf("vec%0d irq cleared", i), irq, 0);
            end
            wait_cycles(CPB);
        end

        // Five back-to-back frames, no pops: the fifth is dropped.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        wait_cycles(4);
        chk("ovr overrun", overrun, 1);
        chk("ovr rx_valid", rx_valid, 1);
        pulse_clr();
        wait_cycles(1);
        chk("ovr cleared", overrun, 0);
        chk("ovr fifo kept", rx_valid, 1);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr pop%0d", i), 8'(i));
        chk("ovr drained", rx_valid, 0);
        wait_cycles(CPB);

        // Pop on exactly the cycle of the fifth push.
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
        fork
            send_frame(8'h05, 1'b1, 1'b0);
            begin
                repeat (PUSH_EDGE) @(posedge clk);
                #1 rx_ready = 1'b1;
                chk("simul head", rx_data, 8'h01);
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        wait_cycles(4);
        chk("simul overrun", overrun, 0);
        for (int i = 2; i <= 5; i++) pop_check($sformatf("simul pop%0d", i), 8'(i));
        chk("simul drained", rx_valid, 0);
        wait_cycles(CPB);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cycles(4);
        chk("par bad parity_err", parity_err, 1);
        chk("par bad rx_valid", rx_valid, 0);
        chk("par bad irq", irq, 1);
        pulse_clr();
        wait_cycles(1);
        chk("par cleared", parity_err, 0);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_cycles(4);
        chk("par good parity_err", parity_err, 0);
        chk("par good rx_valid", rx_valid, 1);
        pop_check("par good rx_data", 8'h07);
        wait_cycles(CPB);
`endif

        // Reset while mid-DATA with a byte already queued.
        send_frame(8'h77, 1'b1, 1'b0);
        wait_cycles(4);
        chk("pre-reset rx_valid", rx_valid, 1);
        rx = 1'b0;
        wait_cycles(CPB);
        rx = 1'b1;
        wait_cycles(CPB);
        rx = 1'b0;
        wait_cycles(20);
        rst = 1'b1;
        wait_cycles(1);
        chk("midrst rx_valid", rx_valid, 0);
        chk("midrst rx_data", rx_data, 0);
        chk("midrst frame_err", frame_err, 0);
        chk("midrst overrun", overrun, 0);
        chk("midrst irq", irq, 0);
        wait_cycles(2);
        rx = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(3 * CPB);
        chk("postrst rx_valid", rx_valid, 0);
        chk("postrst frame_err", frame_err, 0);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_cycles(4);
        chk("postrst frame rx_valid", rx_valid, 1);
        chk("postrst frame rx_data", rx_data, 8'h5A);
        chk("postrst frame_err2", frame_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
